// File: rtl/mcdf_pkg.sv
// -----------------------------------------------------------------------------
// mcdf_pkg
// Shared definitions for the MCDF formatter slice: channel count, formatter
// FSM state encoding, packet length-select encodings and small helpers.
// -----------------------------------------------------------------------------
package mcdf_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_WIN = 2'd1,
    ST_REQ      = 2'd2,
    ST_SEND     = 2'd3
  } fmt_state_e;

  typedef enum logic [1:0] {
    LEN_SEL_4  = 2'b00,
    LEN_SEL_8  = 2'b01,
    LEN_SEL_16 = 2'b10,
    LEN_SEL_32 = 2'b11
  } len_sel_e;

  // Packet length in words for a 2-bit length select.
  function automatic int unsigned len_decode(input logic [1:0] sel);
    int unsigned len;
    case (sel)
      LEN_SEL_4:  len = 4;
      LEN_SEL_8:  len = 8;
      LEN_SEL_16: len = 16;
      default:    len = 32;
    endcase
    return len;
  endfunction

  // Index of the set bit of a one-hot channel vector (caller guarantees one-hot).
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_CH-1:0] vec);
    logic [1:0] idx;
    idx = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (vec[n]) idx = 2'(n);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mcdf_fmt_elig.sv
// -----------------------------------------------------------------------------
// mcdf_fmt_elig
// Per-channel packet length decode and eligibility: a channel may request
// arbitration when it is enabled and its FIFO holds at least one full packet.
// Purely combinational.
//
// Ports:
//   ch_en_i       per-channel enable
//   ch_len_sel_i  2-bit length select per channel, ch n at [2n+1:2n]
//   ch_level_i    FIFO fill level per channel, ch n at [LW*n +: LW]
//   ch_len_o      decoded packet length per channel, ch n at [LW*n +: LW]
//   elig_o        per-channel eligibility (arbiter request vector)
// -----------------------------------------------------------------------------
module mcdf_fmt_elig
  import mcdf_pkg::*;
#(
  parameter int LW = 6
) (
  input  logic [NUM_CH-1:0]    ch_en_i,
  input  logic [2*NUM_CH-1:0]  ch_len_sel_i,
  input  logic [NUM_CH*LW-1:0] ch_level_i,
  output logic [NUM_CH*LW-1:0] ch_len_o,
  output logic [NUM_CH-1:0]    elig_o
);

  // NOTE: every combinational output gets a default before any conditional
  // or looped assignment, so no path leaves it unassigned and no latch forms.
  always_comb begin
    ch_len_o = '0;
    elig_o   = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      ch_len_o[n*LW +: LW] = LW'(len_decode(ch_len_sel_i[2*n +: 2]));
      elig_o[n] = ch_en_i[n] && (ch_level_i[n*LW +: LW] >= ch_len_o[n*LW +: LW]);
    end
  end

endmodule

// File: rtl/mcdf_formatter.sv
// -----------------------------------------------------------------------------
// mcdf_formatter
// Consumer side of the MCDF 4-channel arbiter. Requests arbitration for every
// channel holding a full packet, takes the registered one-hot winner, then
// drains exactly one packet from that channel's show-ahead FIFO and streams it
// downstream (req/grant, then valid/ready with start/end markers).
//
// Ports:
//   clk_i, rst_n_i            clock, async active-low reset
//   ch_en_i, ch_len_sel_i     channel enables and length selects
//   ch_level_i, ch_data_i     FIFO levels and head words (show-ahead)
//   ch_pop_o                  one-hot FIFO pop, one word per accepted beat
//   arb_req_vec_o             eligibility vector to the arbiter
//   arb_trigger_o             one-cycle arbitration start pulse
//   arb_win_vec_i             registered winner, valid the cycle after trigger
//   fmt_req_o/fmt_grant_i     packet request handshake
//   fmt_chid_o/fmt_length_o   channel id and length of the current packet
//   fmt_valid_o/fmt_ready_i   beat handshake, fmt_data_o beat data
//   fmt_start_o/fmt_end_o     first/last beat markers (qualified by valid)
//   fmt_idle_o                FSM idle
//   err_o                     sticky: winner was not one-hot
// -----------------------------------------------------------------------------
module mcdf_formatter
  import mcdf_pkg::*;
#(
  parameter int DW = 32,
  parameter int LW = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NUM_CH-1:0]    ch_en_i,
  input  logic [2*NUM_CH-1:0]  ch_len_sel_i,
  input  logic [NUM_CH*LW-1:0] ch_level_i,
  input  logic [NUM_CH*DW-1:0] ch_data_i,
  output logic [NUM_CH-1:0]    ch_pop_o,
  output logic [NUM_CH-1:0]    arb_req_vec_o,
  output logic                 arb_trigger_o,
  input  logic [NUM_CH-1:0]    arb_win_vec_i,
  output logic                 fmt_req_o,
  input  logic                 fmt_grant_i,
  output logic [1:0]           fmt_chid_o,
  output logic [LW-1:0]        fmt_length_o,
  output logic                 fmt_valid_o,
  input  logic                 fmt_ready_i,
  output logic [DW-1:0]        fmt_data_o,
  output logic                 fmt_start_o,
  output logic                 fmt_end_o,
  output logic                 fmt_idle_o,
  output logic                 err_o
);

  logic [NUM_CH-1:0]    elig;
  logic [NUM_CH*LW-1:0] ch_len;
  logic [1:0]           win_idx;
  logic                 win_multi;

  fmt_state_e    state_q, state_d;
  logic [1:0]    chid_q, chid_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  mcdf_fmt_elig #(.LW(LW)) u_elig (
    .ch_en_i      (ch_en_i),
    .ch_len_sel_i (ch_len_sel_i),
    .ch_level_i   (ch_level_i),
    .ch_len_o     (ch_len),
    .elig_o       (elig)
  );

  assign arb_req_vec_o = elig;

  // x & (x-1) clears the lowest set bit; anything left means two or more bits.
  assign win_multi = (arb_win_vec_i & (arb_win_vec_i - NUM_CH'(1))) != '0;
  assign win_idx   = onehot_to_idx(arb_win_vec_i);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      chid_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chid_q  <= chid_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    chid_d        = chid_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    arb_trigger_o = 1'b0;
    fmt_req_o     = 1'b0;
    fmt_valid_o   = 1'b0;
    fmt_data_o    = '0;
    fmt_start_o   = 1'b0;
    fmt_end_o     = 1'b0;
    ch_pop_o      = '0;

    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          arb_trigger_o = 1'b1;
          state_d       = ST_WAIT_WIN;
        end
      end

      ST_WAIT_WIN: begin
        if (arb_win_vec_i == '0) begin
          state_d = ST_IDLE;
        end else if (win_multi) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          // Channel and length are frozen here for the whole packet.
          chid_d  = win_idx;
          len_d   = ch_len[win_idx*LW +: LW];
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        fmt_req_o = 1'b1;
        if (fmt_grant_i) begin
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        fmt_valid_o = 1'b1;
        fmt_data_o  = ch_data_i[chid_q*DW +: DW];
        fmt_start_o = (cnt_q == '0);
        fmt_end_o   = (cnt_q == len_q - LW'(1));
        if (fmt_ready_i) begin
          ch_pop_o[chid_q] = 1'b1;
          cnt_d            = cnt_q + LW'(1);
          if (fmt_end_o) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Packet descriptors are only meaningful while a packet is being offered.
  assign fmt_chid_o   = (state_q == ST_REQ || state_q == ST_SEND) ? chid_q : '0;
  assign fmt_length_o = (state_q == ST_REQ || state_q == ST_SEND) ? len_q  : '0;
  assign fmt_idle_o   = (state_q == ST_IDLE);
  assign err_o        = err_q;

endmodule

// File: tb/tb_mcdf_formatter.sv
// -----------------------------------------------------------------------------
// tb_mcdf_formatter
// Bench for mcdf_formatter. Models the four show-ahead FIFOs as queues, a
// round-robin arbiter answering each trigger, and downstream grant/ready.
// Every winning arbitration pushes the expected beats of that packet into a
// scoreboard queue; a monitor on the falling edge compares each accepted beat.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mcdf_formatter;

  localparam int DW = 32;
  localparam int LW = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      ch_en;
  logic [7:0]      ch_len_sel;
  logic [4*LW-1:0] ch_level;
  logic [4*DW-1:0] ch_data;
  logic [3:0]      ch_pop;
  logic [3:0]      arb_req_vec;
  logic            arb_trigger;
  logic [3:0]      arb_win_vec;
  logic            fmt_req, fmt_grant;
  logic [1:0]      fmt_chid;
  logic [LW-1:0]   fmt_length;
  logic            fmt_valid, fmt_ready;
  logic [DW-1:0]   fmt_data;
  logic            fmt_start, fmt_end, fmt_idle, err;

  always #5 clk = ~clk;

  mcdf_formatter #(.DW(DW), .LW(LW)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .ch_en_i       (ch_en),
    .ch_len_sel_i  (ch_len_sel),
    .ch_level_i    (ch_level),
    .ch_data_i     (ch_data),
    .ch_pop_o      (ch_pop),
    .arb_req_vec_o (arb_req_vec),
    .arb_trigger_o (arb_trigger),
    .arb_win_vec_i (arb_win_vec),
    .fmt_req_o     (fmt_req),
    .fmt_grant_i   (fmt_grant),
    .fmt_chid_o    (fmt_chid),
    .fmt_length_o  (fmt_length),
    .fmt_valid_o   (fmt_valid),
    .fmt_ready_i   (fmt_ready),
    .fmt_data_o    (fmt_data),
    .fmt_start_o   (fmt_start),
    .fmt_end_o     (fmt_end),
    .fmt_idle_o    (fmt_idle),
    .err_o         (err)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    chid;
    logic [LW-1:0] len;
    logic          first;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] fifo [4][$];
  int            inject_q[$];

  int n_err = 0;
  int n_checks = 0;
  int trig_cnt = 0;
  int beats_seen = 0;
  int pops_seen [4] = '{0, 0, 0, 0};

  // arbiter / downstream model state
  logic [3:0] pop_cap = '0;
  bit         trig_pending = 0;
  logic [3:0] req_at_trig = '0;
  int         rr_last = 3;
  int         grant_delay = 1;
  int         req_cnt = 0;
  int         ready_mode = 0;
  bit         tog = 1;
  int         drv_w, drv_len;
  bit         drv_found;
  beat_t      drv_b;

  // monitor state
  logic [3:0]    exp_elig;
  beat_t         mon_e;
  bit            prev_end = 0, prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic          prev_first, prev_last;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Packet length straight from the select: 4 words doubled per step.
  function automatic int model_len(input int n);
    return 4 << ch_len_sel[2*n +: 2];
  endfunction

  task automatic refresh();
    for (int n = 0; n < 4; n++) begin
      ch_level[n*LW +: LW] = LW'((fifo[n].size() > 63) ? 63 : fifo[n].size());
      ch_data[n*DW +: DW]  = (fifo[n].size() > 0) ? fifo[n][0] : '0;
    end
  endtask

  task automatic push(input int ch, input int n);
    for (int i = 0; i < n; i++) fifo[ch].push_back($urandom);
    refresh();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    inject_q.delete();
    trig_pending = 0;
  endtask

  task automatic wait_pops(input int ch, input int target, input string name);
    int g = 0;
    while (pops_seen[ch] < target && g < 1000) begin
      @(posedge clk);
      g++;
    end
    check(name, 64'(pops_seen[ch] >= target), 64'(1));
  endtask

  // Wait until the DUT is not in the arbitration window, then hand control
  // back at posedge+2 so configuration may change.
  task automatic safe_slot();
    int g = 0;
    @(posedge clk); #2;
    while (!(fmt_idle || fmt_req || fmt_valid) && g < 10) begin
      @(posedge clk); #2;
      g++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Environment driver: FIFO pops, arbiter answer, grant and ready (posedge+1)
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    #1;
    for (int n = 0; n < 4; n++) begin
      if (pop_cap[n] && fifo[n].size() > 0) void'(fifo[n].pop_front());
    end
    arb_win_vec = '0;
    if (trig_pending && rst_n) begin
      trig_pending = 0;
      if (inject_q.size() > 0) begin
        arb_win_vec = 4'(inject_q.pop_front());
      end else begin
        drv_found = 0;
        drv_w = 0;
        for (int i = 1; i <= 4; i++) begin
          if (!drv_found && req_at_trig[(rr_last + i) % 4]) begin
            drv_found = 1;
            drv_w = (rr_last + i) % 4;
          end
        end
        if (drv_found) begin
          rr_last = drv_w;
          arb_win_vec = 4'(1 << drv_w);
          drv_len = model_len(drv_w);
          for (int i = 0; i < drv_len; i++) begin
            drv_b.data  = (i < fifo[drv_w].size()) ? fifo[drv_w][i] : '0;
            drv_b.chid  = 2'(drv_w);
            drv_b.len   = LW'(drv_len);
            drv_b.first = (i == 0);
            drv_b.last  = (i == drv_len - 1);
            exp_q.push_back(drv_b);
          end
        end
      end
    end
    refresh();
    req_cnt = fmt_req ? req_cnt + 1 : 0;
    fmt_grant = fmt_req && (req_cnt >= grant_delay);
    case (ready_mode)
      1: begin
        if (fmt_valid) begin
          fmt_ready = tog;
          tog = ~tog;
        end else begin
          fmt_ready = 1'b1;
          tog = 1;
        end
      end
      2: fmt_ready = 1'($urandom_range(0, 1));
      default: fmt_ready = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard (negedge)
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_n) begin
      pop_cap    = '0;
      prev_end   = 0;
      prev_stall = 0;
    end else begin
      for (int n = 0; n < 4; n++)
        exp_elig[n] = ch_en[n] && (fifo[n].size() >= model_len(n));
      check("req_vec", 64'(arb_req_vec), 64'(exp_elig));
      if (arb_trigger) begin
        trig_cnt++;
        trig_pending = 1;
        req_at_trig  = exp_elig;
      end
      if (prev_end) check("idle_after_end", 64'(fmt_idle), 64'(1));
      if (prev_stall)
        check("stall_hold", 64'({fmt_valid, fmt_data, fmt_start, fmt_end}),
              64'({1'b1, prev_data, prev_first, prev_last}));
      if (fmt_valid && fmt_ready) begin
        check("beat_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("beat", 64'({fmt_data, fmt_chid, fmt_length, fmt_start, fmt_end, ch_pop}),
                64'({mon_e.data, mon_e.chid, mon_e.len, mon_e.first, mon_e.last,
                     4'(1 << mon_e.chid)}));
        end
        for (int n = 0; n < 4; n++) if (ch_pop[n]) pops_seen[n]++;
        beats_seen++;
      end else begin
        check("no_pop", 64'(ch_pop), 64'(0));
      end
      pop_cap    = ch_pop;
      prev_end   = fmt_valid && fmt_ready && fmt_end;
      prev_stall = fmt_valid && !fmt_ready;
      prev_data  = fmt_data;
      prev_first = fmt_start;
      prev_last  = fmt_end;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int g, n, base_beats, base_pops;
    ch_en = '0; ch_len_sel = '0; arb_win_vec = '0;
    fmt_grant = 1'b0; fmt_ready = 1'b1;
    refresh();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          64'({arb_trigger, arb_req_vec, ch_pop, fmt_req, fmt_valid, fmt_start, fmt_end,
               fmt_chid, fmt_length, fmt_data, err, fmt_idle}), 64'(1));
    @(posedge clk); #2 rst_n = 1'b1;

    // single 4-word packet on ch0, grant and ready always high
    @(posedge clk); #2;
    ch_en = 4'b0001; ch_len_sel = 8'h00;
    push(0, 4);
    wait_pops(0, 4, "t1_done");
    repeat (3) @(negedge clk);
    check("t1_triggers", 64'(trig_cnt), 64'(1));
    check("t1_pops", 64'(pops_seen[0]), 64'(4));
    check("t1_idle", 64'(fmt_idle), 64'(1));

    // one word short of a packet: no request, no trigger
    @(posedge clk); #2;
    push(0, 3);
    repeat (10) begin
      @(negedge clk);
      check("t2_quiet", 64'({fmt_idle, arb_trigger, arb_req_vec}), 64'({1'b1, 1'b0, 4'b0000}));
    end
    check("t2_triggers", 64'(trig_cnt), 64'(1));
    @(posedge clk); #2;
    push(0, 1);
    wait_pops(0, 8, "t2_done");

    // 8-word packet on ch2, ready toggling
    safe_slot();
    ch_en = 4'b0100; ch_len_sel = 8'b00_01_00_00; ready_mode = 1;
    push(2, 8);
    wait_pops(2, 8, "t3_done");
    repeat (5) @(posedge clk);
    check("t3_pops", 64'(pops_seen[2]), 64'(8));
    ready_mode = 0;

    // grant delayed: request held 5 cycles with stable descriptors
    safe_slot();
    ch_en = 4'b0010; ch_len_sel = 8'h00; grant_delay = 5;
    push(1, 4);
    g = 0;
    @(negedge clk);
    while (!fmt_req && g < 50) begin @(negedge clk); g++; end
    n = 0;
    while (fmt_req && n < 50) begin
      check("t4_req_hold", 64'({fmt_chid, fmt_length, ch_pop, fmt_valid}),
            64'({2'd1, 6'd4, 4'b0000, 1'b0}));
      n++;
      @(negedge clk);
    end
    check("t4_req_cycles", 64'(n), 64'(5));
    wait_pops(1, 4, "t4_done");
    grant_delay = 1;

    // zero winner (no error), then multi-hot winner (sticky error)
    safe_slot();
    inject_q.push_back(0);
    inject_q.push_back(6);
    ch_en = 4'b1000; ch_len_sel = 8'h00;
    push(3, 4);
    g = 0;
    do begin @(posedge clk); g++; end while (inject_q.size() > 1 && g < 100);
    @(negedge clk);
    check("t5_zero_win", 64'({err, fmt_idle, fmt_req}), 64'({1'b0, 1'b1, 1'b0}));
    g = 0;
    do begin @(posedge clk); g++; end while (inject_q.size() > 0 && g < 100);
    @(negedge clk);
    check("t5_multi_win", 64'({err, fmt_idle, fmt_req}), 64'({1'b1, 1'b1, 1'b0}));
    wait_pops(3, 4, "t5_done");
    repeat (3) @(posedge clk);
    check("t5_err_sticky", 64'(err), 64'(1));

    // 32-word packet: longest length
    safe_slot();
    ch_len_sel = 8'hFF;
    push(3, 32);
    wait_pops(3, 36, "t6_len32_done");

    // reset after beat 2 of a 16-word packet
    safe_slot();
    ch_en = 4'b0001; ch_len_sel = 8'b00_00_00_10;
    base_beats = beats_seen;
    push(0, 16);
    g = 0;
    do begin @(posedge clk); g++; end while (beats_seen < base_beats + 3 && g < 200);
    #2 do_reset();
    #1;
    check("t7_reset_mid",
          64'({arb_trigger, arb_req_vec, ch_pop, fmt_req, fmt_valid, fmt_start, fmt_end,
               fmt_chid, fmt_length, fmt_data, err, fmt_idle}), 64'(1));
    check("t7_fifo_left", 64'(fifo[0].size()), 64'(13));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    base_pops = pops_seen[0];
    push(0, 3);
    wait_pops(0, base_pops + 16, "t7_after_reset");
    repeat (3) @(posedge clk);
    check("t7_err_cleared", 64'(err), 64'(0));

    // randomized traffic with stalls and random grant latency
    ready_mode = 2;
    for (int r = 0; r < 8; r++) begin
      safe_slot();
      ch_en       = 4'($urandom);
      ch_len_sel  = 8'($urandom);
      grant_delay = $urandom_range(1, 3);
      for (int c = 0; c < 4; c++)
        if (fifo[c].size() < 30) push(c, $urandom_range(0, 20));
      repeat (150) @(posedge clk);
    end

    // drain
    safe_slot();
    ch_en = '0;
    g = 0;
    while (!fmt_idle && g < 500) begin @(posedge clk); g++; end
    repeat (5) @(posedge clk);
    check("drain_idle", 64'(fmt_idle), 64'(1));
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
